// File: rtl/fb_arbiter_if.sv
// Burst command bus between the frame-buffer arbiter and the memory controller.
//
// Handshake: the master raises cmd_valid together with cmd_we/cmd_addr/cmd_len.
// It holds all of them stable until the slave answers with cmd_ready.
// The command is transferred on the rising clock edge where both are high.
// cmd_valid never drops before that edge, except under reset.
// After a transfer the slave pulses mem_done for one cycle once the burst data phase is complete.
interface fb_arbiter_if #(
    parameter int ADDR_W = 24,
    parameter int LEN_W  = 8
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              mem_done;

    modport master (
        output cmd_valid, cmd_we, cmd_addr, cmd_len,
        input  cmd_ready, mem_done
    );

    modport slave (
        input  cmd_valid, cmd_we, cmd_addr, cmd_len,
        output cmd_ready, mem_done
    );
endinterface

// File: rtl/fb_arbiter.sv
// Triple-buffered frame-buffer arbiter: shares one burst command port between
// the camera write path and the display read path, with read priority, a
// write anti-starvation streak limit and vsync-driven bank rotation.
module fb_arbiter #(
    parameter int   ADDR_W        = 24,
    parameter int   LEN_W         = 8,
    parameter int   BURST_LEN     = 64,
    parameter int   FRAME_WORDS   = 384000,
    parameter int   BANK_STRIDE   = 524288,
    parameter int   LVL_W         = 10,
    parameter int   RD_FIFO_DEPTH = 512,
    parameter int   RD_STREAK     = 4,
    parameter logic VS_POL        = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cam_vs,
    input  logic              disp_vs,
    input  logic [LVL_W-1:0]  wr_fifo_level,
    input  logic [LVL_W-1:0]  rd_fifo_level,
    fb_arbiter_if.master      bus,
    output logic              wr_grant,
    output logic              rd_grant,
    output logic [1:0]        wr_bank,
    output logic [1:0]        rd_bank,
    output logic              wr_frame_full,
    output logic [2:0]        state_dbg
);
    localparam int STK_W = $clog2(RD_STREAK + 1);
    localparam logic [ADDR_W-1:0] FRAME_A = ADDR_W'(FRAME_WORDS);
    localparam logic [ADDR_W-1:0] BURST_A = ADDR_W'(BURST_LEN);
    localparam logic [LVL_W-1:0]  RD_ROOM = LVL_W'(RD_FIFO_DEPTH - BURST_LEN);
    localparam logic [LVL_W-1:0]  WR_MIN  = LVL_W'(BURST_LEN);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SYNC    = 3'd1,
        RD_CMD  = 3'd2,
        RD_DATA = 3'd3,
        WR_CMD  = 3'd4,
        WR_DATA = 3'd5
    } state_t;

    state_t            state, next_state;
    logic              cam_vs_q, cam_vs_q2, disp_vs_q, disp_vs_q2;
    logic              cam_pend, disp_pend;
    logic              cam_edge, disp_edge;
    logic [1:0]        done_bank;
    logic [ADDR_W-1:0] wr_off, rd_off;
    logic [STK_W-1:0]  streak;
    logic              rd_req, wr_req;
    logic [ADDR_W-1:0] cmd_addr_q;
    logic              cmd_we_q;

    function automatic logic [ADDR_W-1:0] bank_base(input logic [1:0] b);
        case (b)
            2'd1:    bank_base = ADDR_W'(BANK_STRIDE);
            2'd2:    bank_base = ADDR_W'(2 * BANK_STRIDE);
            default: bank_base = '0;
        endcase
    endfunction

    assign cam_edge  = (cam_vs_q == VS_POL) && (cam_vs_q2 != VS_POL);
    assign disp_edge = (disp_vs_q == VS_POL) && (disp_vs_q2 != VS_POL);
    assign rd_req    = (rd_fifo_level <= RD_ROOM) && (rd_off < FRAME_A);
    assign wr_req    = (wr_fifo_level >= WR_MIN) && (wr_off < FRAME_A);

    assign bus.cmd_addr  = cmd_addr_q;
    assign bus.cmd_we    = cmd_we_q;
    assign bus.cmd_len   = LEN_W'(BURST_LEN);
    assign wr_frame_full = (wr_off == FRAME_A);
    assign state_dbg     = state;

    // Register vsync inputs and keep frame-start events pending until SYNC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cam_vs_q   <= ~VS_POL;
            cam_vs_q2  <= ~VS_POL;
            disp_vs_q  <= ~VS_POL;
            disp_vs_q2 <= ~VS_POL;
            cam_pend   <= 1'b0;
            disp_pend  <= 1'b0;
        end else begin
            cam_vs_q   <= cam_vs;
            cam_vs_q2  <= cam_vs_q;
            disp_vs_q  <= disp_vs;
            disp_vs_q2 <= disp_vs_q;
            cam_pend   <= cam_edge  | (cam_pend  & (state != SYNC));
            disp_pend  <= disp_edge | (disp_pend & (state != SYNC));
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state selection, command valid and grant pulses.
    always_comb begin
        next_state    = state;
        bus.cmd_valid = 1'b0;
        rd_grant      = 1'b0;
        wr_grant      = 1'b0;
        case (state)
            IDLE: begin
                if (cam_pend || disp_pend)                        next_state = SYNC;
                else if (wr_req && streak == STK_W'(RD_STREAK))   next_state = WR_CMD;
                else if (rd_req)                                  next_state = RD_CMD;
                else if (wr_req)                                  next_state = WR_CMD;
            end
            SYNC: next_state = IDLE;
            RD_CMD: begin
                bus.cmd_valid = 1'b1;
                if (bus.cmd_ready) begin
                    rd_grant   = 1'b1;
                    next_state = RD_DATA;
                end
            end
            WR_CMD: begin
                bus.cmd_valid = 1'b1;
                if (bus.cmd_ready) begin
                    wr_grant   = 1'b1;
                    next_state = WR_DATA;
                end
            end
            RD_DATA, WR_DATA: if (bus.mem_done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Banks, offsets, streak counter and the command latch (loaded only from IDLE).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank    <= 2'd1;
            rd_bank    <= 2'd0;
            done_bank  <= 2'd0;
            wr_off     <= '0;
            rd_off     <= '0;
            streak     <= '0;
            cmd_addr_q <= '0;
            cmd_we_q   <= 1'b0;
        end else begin
            if (state == SYNC) begin
                if (cam_pend) begin
                    done_bank <= wr_bank;
                    wr_bank   <= (wr_bank == rd_bank) ? ((wr_bank == 2'd2) ? 2'd0 : wr_bank + 2'd1)
                                                      : (2'd3 - wr_bank - rd_bank);
                    wr_off    <= '0;
                end
                if (disp_pend) begin
                    rd_bank <= cam_pend ? wr_bank : done_bank;
                    rd_off  <= '0;
                end
            end
            if (rd_grant) rd_off <= (rd_off >= FRAME_A - BURST_A) ? FRAME_A : rd_off + BURST_A;
            if (wr_grant) wr_off <= (wr_off >= FRAME_A - BURST_A) ? FRAME_A : wr_off + BURST_A;

            if (!wr_req || wr_grant)                        streak <= '0;
            else if (rd_grant && streak < STK_W'(RD_STREAK)) streak <= streak + 1'b1;

            if (state == IDLE && next_state == RD_CMD) begin
                cmd_we_q   <= 1'b0;
                cmd_addr_q <= bank_base(rd_bank) + rd_off;
            end else if (state == IDLE && next_state == WR_CMD) begin
                cmd_we_q   <= 1'b1;
                cmd_addr_q <= bank_base(wr_bank) + wr_off;
            end
        end
    end
endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter: memory responder with a grant budget,
// command scoreboard, and one task per scenario.
module tb_fb_arbiter;
    localparam int STRIDE = 524288;
    localparam logic [2:0] ST_IDLE = 3'd0, ST_RD_DATA = 3'd3, ST_WR_CMD = 3'd4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cam_vs = 1'b1, disp_vs = 1'b1;
    logic [9:0] wr_fifo_level = '0, rd_fifo_level = 10'd500;
    logic       wr_grant, rd_grant, wr_frame_full;
    logic [1:0] wr_bank, rd_bank;
    logic [2:0] state_dbg;

    fb_arbiter_if bus ();

    fb_arbiter dut (
        .clk(clk), .rst_n(rst_n), .cam_vs(cam_vs), .disp_vs(disp_vs),
        .wr_fifo_level(wr_fifo_level), .rd_fifo_level(rd_fifo_level),
        .bus(bus), .wr_grant(wr_grant), .rd_grant(rd_grant),
        .wr_bank(wr_bank), .rd_bank(rd_bank), .wr_frame_full(wr_frame_full),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;
    int budget = 0;
    int ready_delay = 0;
    int wait_cnt = 0;
    int done_cnt = 0;
    logic [24:0] exp_q[$];

    // Memory responder: accepts up to 'budget' commands, ready after
    // 'ready_delay' cycles, mem_done three cycles after acceptance.
    initial begin
        bus.cmd_ready = 1'b0;
        bus.mem_done  = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.mem_done = 1'b0;
            if (!rst_n) begin
                bus.cmd_ready = 1'b0;
                done_cnt = 0;
                wait_cnt = 0;
            end else if (bus.cmd_ready) begin
                bus.cmd_ready = 1'b0;
                done_cnt = 3;
            end else if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) bus.mem_done = 1'b1;
            end else if (bus.cmd_valid && budget > 0) begin
                if (wait_cnt >= ready_delay) begin
                    bus.cmd_ready = 1'b1;
                    wait_cnt = 0;
                    budget--;
                end else wait_cnt++;
            end
        end
    end

    // Scoreboard and command-stability monitor.
    logic        prev_valid = 1'b0;
    logic [24:0] prev_cmd = '0;
    always @(negedge clk) begin
        logic [24:0] got, exp;
        got = {bus.cmd_we, bus.cmd_addr};
        if (rst_n) begin
            if (bus.cmd_valid && prev_valid) begin
                vec_cnt++;
                if (got !== prev_cmd) begin
                    err_cnt++;
                    $display("FAIL cmd_stable: got %h, held value %h", got, prev_cmd);
                end
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                vec_cnt++;
                if (exp_q.size() == 0) begin
                    err_cnt++;
                    $display("FAIL unexpected_cmd: got we=%0b addr=%0d, none expected", got[24], got[23:0]);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        err_cnt++;
                        $display("FAIL cmd: got we=%0b addr=%0d, expected we=%0b addr=%0d",
                                 got[24], got[23:0], exp[24], exp[23:0]);
                    end
                    vec_cnt++;
                    if ({wr_grant, rd_grant} !== (exp[24] ? 2'b10 : 2'b01)) begin
                        err_cnt++;
                        $display("FAIL grant: got wr=%0b rd=%0b for we=%0b", wr_grant, rd_grant, exp[24]);
                    end
                end
            end
            prev_valid = bus.cmd_valid;
            prev_cmd   = got;
        end else prev_valid = 1'b0;
    end

    task automatic do_reset(input logic [9:0] rd_lvl, input logic [9:0] wr_lvl, input int dly);
        @(posedge clk); #2;
        rst_n = 1'b0;
        budget = 0;
        exp_q.delete();
        cam_vs = 1'b1;
        disp_vs = 1'b1;
        rd_fifo_level = rd_lvl;
        wr_fifo_level = wr_lvl;
        ready_delay = dly;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while (exp_q.size() > 0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        vec_cnt++;
        if (exp_q.size() > 0) begin
            err_cnt++;
            $display("FAIL drain: %0d commands still expected after %0d cycles", exp_q.size(), n);
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        do_reset(10'd500, 10'd0, 0);
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if ({bus.cmd_valid, bus.cmd_we, bus.cmd_addr, bus.cmd_len} !== {1'b0, 1'b0, 24'd0, 8'd64}) begin
            err_cnt++;
            $display("FAIL reset_cmd: got v=%0b we=%0b addr=%0d len=%0d, expected 0 0 0 64",
                     bus.cmd_valid, bus.cmd_we, bus.cmd_addr, bus.cmd_len);
        end
        vec_cnt++;
        if ({wr_grant, rd_grant, wr_bank, rd_bank, wr_frame_full, state_dbg} !== {2'b00, 2'd1, 2'd0, 1'b0, ST_IDLE}) begin
            err_cnt++;
            $display("FAIL reset_state: got grants=%0b%0b wr_bank=%0d rd_bank=%0d full=%0b state=%0d",
                     wr_grant, rd_grant, wr_bank, rd_bank, wr_frame_full, state_dbg);
        end
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        vec_cnt++;
        if ({bus.cmd_valid, state_dbg} !== {1'b0, ST_IDLE}) begin
            err_cnt++;
            $display("FAIL idle_no_req: got valid=%0b state=%0d, expected 0 0", bus.cmd_valid, state_dbg);
        end
    endtask

    task automatic test_reads();
        do_reset(10'd0, 10'd0, 0);
        for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, 24'(i * 64)});
        budget = 8;
        wait_drain(200);
    endtask

    task automatic test_streak();
        do_reset(10'd0, 10'd200, $urandom_range(0, 2));
        for (int i = 0; i < 12; i++) begin
            if (i % 5 == 4) exp_q.push_back({1'b1, 24'(STRIDE + (i / 5) * 64)});
            else            exp_q.push_back({1'b0, 24'((i - i / 5) * 64)});
        end
        budget = 12;
        wait_drain(400);
    endtask

    task automatic test_vsync_idle();
        do_reset(10'd500, 10'd0, 0);
        cam_vs = 1'b0;
        repeat (8) @(posedge clk);
        #2 cam_vs = 1'b1;
        vec_cnt++;
        if ({wr_bank, rd_bank} !== {2'd2, 2'd0}) begin
            err_cnt++;
            $display("FAIL cam_swap: got wr_bank=%0d rd_bank=%0d, expected 2 0", wr_bank, rd_bank);
        end
        disp_vs = 1'b0;
        repeat (8) @(posedge clk);
        #2 disp_vs = 1'b1;
        vec_cnt++;
        if ({wr_bank, rd_bank} !== {2'd2, 2'd1}) begin
            err_cnt++;
            $display("FAIL disp_swap: got wr_bank=%0d rd_bank=%0d, expected 2 1", wr_bank, rd_bank);
        end
        exp_q.push_back({1'b0, 24'(STRIDE)});
        rd_fifo_level = 10'd0;
        budget = 1;
        wait_drain(50);
    endtask

    task automatic test_vsync_same();
        do_reset(10'd500, 10'd0, 0);
        cam_vs = 1'b0;
        disp_vs = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        vec_cnt++;
        if ({wr_bank, rd_bank} !== {2'd2, 2'd1}) begin
            err_cnt++;
            $display("FAIL same_cycle_swap: got wr_bank=%0d rd_bank=%0d, expected 2 1", wr_bank, rd_bank);
        end
        exp_q.push_back({1'b0, 24'(STRIDE)});
        rd_fifo_level = 10'd0;
        budget = 1;
        wait_drain(50);
    endtask

    task automatic test_vsync_busy();
        do_reset(10'd500, 10'd0, 5);
        cam_vs = 1'b0;
        repeat (8) @(posedge clk);
        #2 cam_vs = 1'b1;
        exp_q.push_back({1'b0, 24'd0});
        rd_fifo_level = 10'd0;
        budget = 1;
        wait_drain(50);
        #2;
        vec_cnt++;
        if (state_dbg !== ST_RD_DATA) begin
            err_cnt++;
            $display("FAIL busy_state: got state=%0d, expected %0d", state_dbg, ST_RD_DATA);
        end
        disp_vs = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        vec_cnt++;
        if ({state_dbg, rd_bank} !== {ST_RD_DATA, 2'd0}) begin
            err_cnt++;
            $display("FAIL no_midburst_swap: got state=%0d rd_bank=%0d, expected %0d 0", state_dbg, rd_bank, ST_RD_DATA);
        end
        exp_q.push_back({1'b0, 24'(STRIDE)});
        budget = 1;
        wait_drain(60);
        vec_cnt++;
        if (rd_bank !== 2'd1) begin
            err_cnt++;
            $display("FAIL busy_swap: got rd_bank=%0d, expected 1", rd_bank);
        end
    endtask

    task automatic test_frame_full();
        int n;
        do_reset(10'd500, 10'd200, 0);
        for (int i = 0; i < 6000; i++) exp_q.push_back({1'b1, 24'(STRIDE + i * 64)});
        budget = 6001;
        wait_drain(40000);
        repeat (20) @(posedge clk);
        #2;
        vec_cnt++;
        if ({wr_frame_full, bus.cmd_valid, state_dbg} !== {1'b1, 1'b0, ST_IDLE}) begin
            err_cnt++;
            $display("FAIL frame_full: got full=%0b valid=%0b state=%0d, expected 1 0 0",
                     wr_frame_full, bus.cmd_valid, state_dbg);
        end
        // Reset in the middle of a write command.
        do_reset(10'd500, 10'd200, 0);
        n = 0;
        while (state_dbg !== ST_WR_CMD && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        vec_cnt++;
        if ({bus.cmd_valid, bus.cmd_we, bus.cmd_addr} !== {1'b1, 1'b1, 24'(STRIDE)}) begin
            err_cnt++;
            $display("FAIL wr_cmd_pending: got v=%0b we=%0b addr=%0d, expected 1 1 %0d",
                     bus.cmd_valid, bus.cmd_we, bus.cmd_addr, STRIDE);
        end
        #1 rst_n = 1'b0;
        #1;
        vec_cnt++;
        if ({bus.cmd_valid, bus.cmd_we, bus.cmd_addr, wr_bank, rd_bank, wr_frame_full, state_dbg}
            !== {1'b0, 1'b0, 24'd0, 2'd1, 2'd0, 1'b0, ST_IDLE}) begin
            err_cnt++;
            $display("FAIL async_reset: got v=%0b we=%0b addr=%0d wr_bank=%0d rd_bank=%0d full=%0b state=%0d",
                     bus.cmd_valid, bus.cmd_we, bus.cmd_addr, wr_bank, rd_bank, wr_frame_full, state_dbg);
        end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_reads();
        test_streak();
        test_vsync_idle();
        test_vsync_same();
        test_vsync_busy();
        test_frame_full();
        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/fb_arbiter.md
# fb_arbiter

Triple-buffered frame-buffer arbiter that shares one burst memory command port between the camera write path (OV5640 capture FIFO) and the display read path (LCD line FIFO feeding the 800x480 timing generator). It issues fixed-length read/write bursts from FIFO fill levels, gives display reads priority with a write anti-starvation limit, and swaps frame banks on camera and display vertical-sync edges so the display never scans a bank being written.

## Interface
- ADDR_W, 24, memory word-address width
- LEN_W, 8, burst length field width
- BURST_LEN, 64, words per burst; FRAME_WORDS must be a multiple of it
- FRAME_WORDS, 384000, words per frame (800x480)
- BANK_STRIDE, 524288, word distance between bank bases; bank b base = b*BANK_STRIDE
- LVL_W, 10, FIFO level width
- RD_FIFO_DEPTH, 512, display FIFO depth in words
- RD_STREAK, 4, max consecutive read bursts while a write is pending
- VS_POL, 1'b0, active level of both vsync inputs
- clk  in  1  pixel/memory-controller clock
- rst_n  in  1  asynchronous, active-low reset
- cam_vs  in  1  camera vsync, already synchronised to clk
- disp_vs  in  1  display vsync from timing generator
- wr_fifo_level  in  LVL_W  camera FIFO words available
- rd_fifo_level  in  LVL_W  display FIFO words stored
- cmd_valid  out  1  burst command valid
- cmd_ready  in  1  memory accepts command
- cmd_we  out  1  1 = write burst, 0 = read burst
- cmd_addr  out  ADDR_W  burst start word address
- cmd_len  out  LEN_W  burst length (constant BURST_LEN)
- mem_done  in  1  one-cycle pulse, burst data phase complete
- wr_grant / rd_grant  out  1  one-cycle pulse on command acceptance
- wr_bank, rd_bank  out  2  current banks (0..2)
- wr_frame_full  out  1  write offset reached FRAME_WORDS

## Operation
- States: IDLE, SYNC, RD_CMD, RD_DATA, WR_CMD, WR_DATA.
- Frame-start event = registered vsync transitions from inactive to VS_POL. Events set sticky pending flags (cam_pend, disp_pend); a second edge while pending is merged.
- IDLE priority: any pending flag -> SYNC; else rd_req -> RD_CMD; else wr_req -> WR_CMD. Exception: if wr_req and streak counter == RD_STREAK, choose WR_CMD.
- rd_req = (rd_fifo_level <= RD_FIFO_DEPTH-BURST_LEN) and rd_off < FRAME_WORDS. wr_req = (wr_fifo_level >= BURST_LEN) and wr_off < FRAME_WORDS.
- Streak counter: +1 per read grant while wr_req high (saturate at RD_STREAK), cleared on write grant or when wr_req low.
- SYNC (one cycle), applied together, cam first: cam_pend -> done_bank<=wr_bank; wr_bank<= the bank differing from old wr_bank and old rd_bank ((wr_bank+1)%3 if equal); wr_off<=0. disp_pend -> rd_bank<=done_bank (post-cam value); rd_off<=0. Clear both flags; back to IDLE.
- CMD states: cmd_valid=1 with cmd_addr = bank*BANK_STRIDE + off, held stable until cmd_ready. On accept: grant pulse, off += BURST_LEN, go to DATA.
- DATA: wait for mem_done, then IDLE. mem_done outside DATA states is ignored.
- Offsets saturate at FRAME_WORDS (no wrap); only SYNC clears them. wr_frame_full = (wr_off == FRAME_WORDS).
- Vsync edges during a burst stay pending; bank swap only occurs in SYNC, never mid-burst.

## Timing
- Reset values: cmd_valid 0, cmd_we 0, cmd_addr 0, cmd_len BURST_LEN, grants 0, wr_bank 1, rd_bank 0, done_bank 0, offsets 0, pending 0, wr_frame_full 0, state IDLE.
- Reset is asynchronous; mid-burst assertion drops cmd_valid immediately; memory side handles the abandoned burst.
- Vsync edge to SYNC entry: 2 cycles from idle (register + detect), plus remaining burst time if busy.
- IDLE->CMD 1 cycle; cmd_valid visible the cycle CMD is entered; minimum one IDLE cycle between bursts.
- cmd_we/cmd_addr change only while cmd_valid=0.

## Test plan
- Reset, rd_fifo_level=0, wr_fifo_level=0 -> read bursts at addresses 0, 64, 128... in bank 0; rd_grant per accept; no writes.
- rd_fifo_level held 0, wr_fifo_level held 200 -> pattern of 4 reads then 1 write; first write cmd_addr=524288 (bank 1, offset 0).
- cam_vs edge then disp_vs edge in idle -> wr_bank 1->2, done_bank=1, rd_bank=1, next read cmd_addr=524288.
- cam_vs and disp_vs edges same cycle with wr_bank=1, rd_bank=0 -> one SYNC: done_bank=1, wr_bank=2, rd_bank=1.
- disp_vs edge while in RD_DATA with cmd_ready delayed 5 cycles -> burst completes, then SYNC, rd_off=0; no address glitch while cmd_valid high.
- Write 6000 bursts with no cam_vs -> wr_frame_full=1 after offset 384000, wr requests stop; rst_n low mid-WR_CMD -> cmd_valid 0 same cycle, all reset values restored.
